// File: rtl/mem_loader_fsm_if.sv
// rtl/mem_loader_fsm_if.sv - byte-stream and memory-write signal bundle for the memory loader
interface mem_loader_fsm_if #(
  parameter int UART_BITS  = 8,
  parameter int WORD_BITS  = 32,
  parameter int ADDR_BITS  = 32,
  parameter int COUNT_BITS = 16
) ();
  logic                  i_start;
  logic [ADDR_BITS-1:0]  i_base_addr;
  logic                  i_rx_done;
  logic [UART_BITS-1:0]  i_rx_data;
  logic                  o_write_mem;
  logic [ADDR_BITS-1:0]  o_mem_addr;
  logic [WORD_BITS-1:0]  o_mem_data;
  logic                  o_busy;
  logic                  o_done;
  logic [1:0]            o_err_code;
  logic [COUNT_BITS-1:0] o_words_written;

  modport master (
    output i_start, i_base_addr, i_rx_done, i_rx_data,
    input  o_write_mem, o_mem_addr, o_mem_data, o_busy, o_done, o_err_code, o_words_written
  );

  modport slave (
    input  i_start, i_base_addr, i_rx_done, i_rx_data,
    output o_write_mem, o_mem_addr, o_mem_data, o_busy, o_done, o_err_code, o_words_written
  );
endinterface

// File: rtl/mem_loader_fsm.sv
// rtl/mem_loader_fsm.sv - UART byte stream to memory word loader with checksum and timeout
module mem_loader_fsm #(
  parameter int UART_BITS      = 8,
  parameter int WORD_BITS      = 32,
  parameter int ADDR_BITS      = 32,
  parameter int COUNT_BYTES    = 2,
  parameter bit CHECKSUM_EN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic             clk,
  input logic             rst,
  mem_loader_fsm_if.slave bus
);
  localparam int  BPW        = WORD_BITS / UART_BITS;
  localparam int  COUNT_BITS = COUNT_BYTES * UART_BITS;
  localparam int  MAXB       = (BPW > COUNT_BYTES) ? BPW : COUNT_BYTES;
  localparam int  BCW        = $clog2(MAXB + 1);
  localparam int  TW         = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit  TO_EN      = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, GET_COUNT, GET_DATA, WRITE, GET_CSUM, FINISH
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  base_addr;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] words_written;
  logic [WORD_BITS-1:0]  word;
  logic [UART_BITS-1:0]  csum;
  logic [BCW-1:0]        byte_cnt;
  logic [TW-1:0]         idle_cnt;
  logic [1:0]            err_code;

  logic [COUNT_BITS-1:0] count_shift;
  logic [WORD_BITS-1:0]  word_shift;
  logic                  last_hdr, last_dat, more_words, receiving, timeout_hit;

  // Shared decode: shifted-in values, byte-position tests, idle-timeout detection
  always_comb begin
    count_shift = (count << UART_BITS) | COUNT_BITS'(bus.i_rx_data);
    word_shift  = (word << UART_BITS) | WORD_BITS'(bus.i_rx_data);
    last_hdr    = (byte_cnt == BCW'(COUNT_BYTES - 1));
    last_dat    = (byte_cnt == BCW'(BPW - 1));
    more_words  = (({1'b0, words_written} + (COUNT_BITS + 1)'(1)) < {1'b0, count});
    receiving   = (state == GET_COUNT) || (state == GET_DATA) || (state == GET_CSUM);
    timeout_hit = TO_EN && receiving && !bus.i_rx_done &&
                  (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.i_start) state_nxt = GET_COUNT;
      GET_COUNT: begin
        if (bus.i_rx_done && last_hdr) begin
          if (count_shift != '0)  state_nxt = GET_DATA;
          else if (CHECKSUM_EN)   state_nxt = GET_CSUM;
          else                    state_nxt = FINISH;
        end else if (timeout_hit) begin
          state_nxt = FINISH;
        end
      end
      GET_DATA: begin
        if (bus.i_rx_done && last_dat) state_nxt = WRITE;
        else if (timeout_hit)          state_nxt = FINISH;
      end
      WRITE: begin
        if (more_words)       state_nxt = GET_DATA;
        else if (CHECKSUM_EN) state_nxt = GET_CSUM;
        else                  state_nxt = FINISH;
      end
      GET_CSUM: begin
        if (bus.i_rx_done || timeout_hit) state_nxt = FINISH;
      end
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    bus.o_write_mem = (state == WRITE);
    bus.o_busy      = (state != IDLE);
    bus.o_done      = (state == FINISH);
  end

  // Datapath: header/word assembly, checksum, idle timer, error latch, write address/data
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_addr      <= '0;
      count          <= '0;
      words_written  <= '0;
      word           <= '0;
      csum           <= '0;
      byte_cnt       <= '0;
      idle_cnt       <= '0;
      err_code       <= ERR_OK;
      bus.o_mem_addr <= '0;
      bus.o_mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            base_addr     <= bus.i_base_addr;
            count         <= '0;
            words_written <= '0;
            csum          <= '0;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
            err_code      <= ERR_OK;
          end
        end
        GET_COUNT: begin
          if (bus.i_rx_done) begin
            count    <= count_shift;
            csum     <= csum ^ bus.i_rx_data;
            byte_cnt <= last_hdr ? '0 : byte_cnt + BCW'(1);
            idle_cnt <= '0;
          end else if (timeout_hit) begin
            if (err_code == ERR_OK) err_code <= ERR_TOUT;
          end else if (TO_EN) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        GET_DATA: begin
          if (bus.i_rx_done) begin
            word     <= word_shift;
            csum     <= csum ^ bus.i_rx_data;
            byte_cnt <= byte_cnt + BCW'(1);
            idle_cnt <= '0;
            // Load the output registers as the last byte lands so they are valid during WRITE
            if (last_dat) begin
              bus.o_mem_data <= word_shift;
              bus.o_mem_addr <= base_addr + ADDR_BITS'(words_written);
            end
          end else if (timeout_hit) begin
            if (err_code == ERR_OK) err_code <= ERR_TOUT;
          end else if (TO_EN) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        WRITE: begin
          words_written <= words_written + COUNT_BITS'(1);
          byte_cnt      <= '0;
          if (bus.i_rx_done && err_code == ERR_OK) err_code <= ERR_OVR;
        end
        GET_CSUM: begin
          if (bus.i_rx_done) begin
            idle_cnt <= '0;
            if (((csum ^ bus.i_rx_data) != '0) && err_code == ERR_OK) err_code <= ERR_CSUM;
          end else if (timeout_hit) begin
            if (err_code == ERR_OK) err_code <= ERR_TOUT;
          end else if (TO_EN) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        FINISH: begin
          if (bus.i_rx_done && err_code == ERR_OK) err_code <= ERR_OVR;
        end
        default: ;
      endcase
    end
  end

  // Error code and word count are held after the load until the next accepted start
  always_comb begin
    bus.o_err_code      = err_code;
    bus.o_words_written = words_written;
  end
endmodule

// File: tb/tb_mem_loader_fsm.sv
// tb/tb_mem_loader_fsm.sv - scoreboard bench for mem_loader_fsm
module tb_mem_loader_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_loader_fsm_if #(.UART_BITS(8), .WORD_BITS(32), .ADDR_BITS(32), .COUNT_BITS(16)) bus ();

  mem_loader_fsm #(
    .UART_BITS(8), .WORD_BITS(32), .ADDR_BITS(32), .COUNT_BYTES(2),
    .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [7:0] run_x;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (rst && bus.o_write_mem) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.o_mem_addr), 64'(e[63:32]));
        check("wr_data", 64'(bus.o_mem_data), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    run_x = run_x ^ b;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.i_rx_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic start_load(input logic [31:0] base);
    bus.i_base_addr = base;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("busy_after_start", 64'(bus.o_busy), 64'd1);
    run_x = 8'h00;
  endtask

  task automatic do_load(input logic [31:0] base, input logic [15:0] cnt,
                         input logic [31:0] w[$], input logic [7:0] cs_flip, input int dup_word);
    logic [31:0] ww;
    logic [31:0] a;
    start_load(base);
    send_byte(cnt[15:8], 1, 1);
    send_byte(cnt[7:0], 1, 1);
    for (int i = 0; i < w.size(); i++) begin
      ww = w[i];
      a = base + 32'(i);
      exp_q.push_back({a, ww});
      for (int j = 0; j < 4; j++)
        send_byte(ww[31-8*j -: 8], (i == dup_word && j == 3) ? 2 : 1, 1);
    end
    send_byte(run_x ^ cs_flip, 1, 0);
  endtask

  task automatic expect_done(input string tag, input logic [1:0] e_err, input logic [15:0] e_words,
                             input int wr_mark, input int e_wr, input int maxc);
    logic found;
    found = 1'b0;
    for (int n = 0; n < maxc && !found; n++) begin
      @(negedge clk);
      if (bus.o_done) found = 1'b1;
    end
    check({tag, "_done"}, 64'(found), 64'd1);
    check({tag, "_err"}, 64'(bus.o_err_code), 64'(e_err));
    check({tag, "_words"}, 64'(bus.o_words_written), 64'(e_words));
    @(posedge clk); #1;
    check({tag, "_nwrites"}, 64'(wr_cnt - wr_mark), 64'(e_wr));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(bus.o_busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_done"}, 64'(bus.o_done), 64'd0);
    check({tag, "_wr"}, 64'(bus.o_write_mem), 64'd0);
    check({tag, "_err"}, 64'(bus.o_err_code), 64'd0);
    check({tag, "_words"}, 64'(bus.o_words_written), 64'd0);
    check({tag, "_addr"}, 64'(bus.o_mem_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.o_mem_data), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    int mark;
    bus.i_start = 1'b0;
    bus.i_base_addr = '0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    run_x = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: two words, good checksum
    w = '{32'h01020304, 32'hAABBCCDD};
    mark = wr_cnt;
    do_load(32'h10, 16'h0002, w, 8'h00, -1);
    expect_done("t1", 2'b00, 16'd2, mark, 2, 20);

    // T2: same stream, corrupted checksum
    mark = wr_cnt;
    do_load(32'h10, 16'h0002, w, 8'h5A, -1);
    expect_done("t2", 2'b01, 16'd2, mark, 2, 20);

    // T3: zero-count header
    w = {};
    mark = wr_cnt;
    do_load(32'h20, 16'h0000, w, 8'h00, -1);
    expect_done("t3", 2'b00, 16'd0, mark, 0, 20);

    // T4: stream stalls after two data bytes
    mark = wr_cnt;
    start_load(32'h30);
    send_byte(8'h00, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 0);
    expect_done("t4", 2'b10, 16'd0, mark, 0, 80);

    // T5: reset in the middle of a word, then a clean load
    start_load(32'h30);
    send_byte(8'h00, 1, 1);
    send_byte(8'h01, 1, 1);
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("t5_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    w = '{32'hDEADBEEF};
    mark = wr_cnt;
    do_load(32'h40, 16'h0001, w, 8'h00, -1);
    expect_done("t5", 2'b00, 16'd1, mark, 1, 20);

    // T6: address wrap and a byte strobe held into the WRITE cycle
    w = '{32'h11223344, 32'h55667788};
    mark = wr_cnt;
    do_load(32'hFFFF_FFFF, 16'h0002, w, 8'h00, 0);
    expect_done("t6", 2'b11, 16'd2, mark, 2, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
